// File: rtl/operand_scoreboard_pkg.sv
// Shared types and constants for the operand scoreboard.
package operand_scoreboard_pkg;

  localparam int NREG     = 32;
  localparam int SB_CNT_W = 2;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SERIAL  = 2'd1,
    RECOVER = 2'd2
  } sb_state_t;

endpackage

// File: rtl/operand_scoreboard_if.sv
// Decode/RegFile/writeback/execute signal bundle seen by the operand scoreboard.
interface operand_scoreboard_if #(parameter int XLEN = 64);

  logic            id_valid;
  logic            id_ready;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_rd_we;
  logic            id_is_csr;

  logic [4:0]      rf_rs1;
  logic [4:0]      rf_rs2;
  logic [XLEN-1:0] rf_q1;
  logic [XLEN-1:0] rf_q2;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            wb_rd_we;
  logic [XLEN-1:0] wb_data;
  logic            wb_flush;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [4:0]      ex_rd;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rd_we, id_is_csr,
    input  rf_q1, rf_q2,
    input  wb_valid, wb_rd, wb_rd_we, wb_data, wb_flush,
    input  ex_ready,
    output id_ready, rf_rs1, rf_rs2,
    output ex_valid, ex_op1, ex_op2, ex_rd
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rd_we, id_is_csr,
    output rf_q1, rf_q2,
    output wb_valid, wb_rd, wb_rd_we, wb_data, wb_flush,
    output ex_ready,
    input  id_ready, rf_rs1, rf_rs2,
    input  ex_valid, ex_op1, ex_op2, ex_rd
  );

endinterface

// File: rtl/operand_scoreboard_sb_counter_bank.sv
// Per-register outstanding-write counters with busy / saturated / exactly-one flags.
module sb_counter_bank
  import operand_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_en,
  input  logic [4:0]      inc_idx,
  input  logic            dec_en,
  input  logic [4:0]      dec_idx,
  input  logic            clear,
  output logic [NREG-1:0] one,
  output logic [NREG-1:0] busy,
  output logic [NREG-1:0] sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  inc_hot;
  logic [NREG-1:0]  dec_hot;

  assign inc_hot = inc_en ? (NREG'(1) << inc_idx) : '0;
  assign dec_hot = dec_en ? (NREG'(1) << dec_idx) : '0;

  // x0 is hard-wired to zero; an inc and dec on the same register cancel
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear || i == 0) begin
        cnt_d[i] = '0;
      end else if (inc_hot[i] && !dec_hot[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_hot[i] && !inc_hot[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      busy[i] = (cnt_q[i] != '0);
      sat[i]  = (cnt_q[i] == CNT_MAX);
      one[i]  = (cnt_q[i] == CNT_W'(1));
    end
  end

  // a retire with nothing outstanding means decode and writeback disagree
  always_ff @(posedge clk) begin
    if (rst && dec_en && !clear && dec_idx != 5'd0)
      assert (cnt_q[dec_idx] != '0);
  end

endmodule

// File: rtl/operand_scoreboard.sv
// Operand scoreboard between decode and execute: RAW stalls, CSR serialisation, execute buffer.
// Optional SCOREBOARD_BYPASS_EN: forward retiring wb_data to a source whose last write retires now.
//
// state   | meaning
// RUN     | normal issue
// SERIAL  | CSR-class op in flight, issue held until writeback retires or redirects
// RECOVER | one dead cycle after a redirect
module operand_scoreboard
  import operand_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W,
  parameter int XLEN  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_scoreboard_if.slave  bus
);

  localparam logic [1:0] ST_RUN     = RUN;
  localparam logic [1:0] ST_SERIAL  = SERIAL;
  localparam logic [1:0] ST_RECOVER = RECOVER;

  logic [1:0]      state_q, state_d;
  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_op1_q, ex_op1_d;
  logic [XLEN-1:0] ex_op2_q, ex_op2_d;
  logic [4:0]      ex_rd_q, ex_rd_d;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] sat;
  logic            wb_we;
  logic            byp1, byp2;
  logic            haz1, haz2;
  logic            id_ready;
  logic            issue;
  logic [XLEN-1:0] op1, op2;

  assign wb_we = bus.wb_valid && bus.wb_rd_we;

`ifdef SCOREBOARD_BYPASS_EN
  logic [NREG-1:0] cnt_one;
  assign byp1 = cnt_one[bus.id_rs1] && wb_we && (bus.wb_rd == bus.id_rs1);
  assign byp2 = cnt_one[bus.id_rs2] && wb_we && (bus.wb_rd == bus.id_rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  sb_counter_bank #(.CNT_W(CNT_W)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (issue && bus.id_rd_we),
    .inc_idx (bus.id_rd),
    .dec_en  (wb_we),
    .dec_idx (bus.wb_rd),
    .clear   (bus.wb_flush),
`ifdef SCOREBOARD_BYPASS_EN
    .one     (cnt_one),
`else
    .one     (),
`endif
    .busy    (busy),
    .sat     (sat)
  );

  // busy[0] is never set, so x0 sources cannot stall
  assign haz1 = busy[bus.id_rs1] && !byp1;
  assign haz2 = busy[bus.id_rs2] && !byp2;
  assign op1  = byp1 ? bus.wb_data : bus.rf_q1;
  assign op2  = byp2 ? bus.wb_data : bus.rf_q2;

  assign id_ready = rst && (state_q == ST_RUN) && !bus.wb_flush
                    && (!ex_valid_q || bus.ex_ready)
                    && !haz1 && !haz2 && !sat[bus.id_rd];
  assign issue    = bus.id_valid && id_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.wb_flush)                 state_d = ST_RECOVER;
        else if (issue && bus.id_is_csr)  state_d = ST_SERIAL;
      end
      ST_SERIAL: begin
        if (bus.wb_flush)                 state_d = ST_RECOVER;
        else if (bus.wb_valid)            state_d = ST_RUN;
      end
      ST_RECOVER:                         state_d = ST_RUN;
      default:                            state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op1_d   = ex_op1_q;
    ex_op2_d   = ex_op2_q;
    ex_rd_d    = ex_rd_q;
    if (bus.wb_flush) begin
      ex_valid_d = 1'b0;
    end else if (issue) begin
      ex_valid_d = 1'b1;
      ex_op1_d   = op1;
      ex_op2_d   = op2;
      ex_rd_d    = bus.id_rd;
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      ex_valid_q <= 1'b0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      ex_op1_q   <= ex_op1_d;
      ex_op2_q   <= ex_op2_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign bus.id_ready = id_ready;
  assign bus.rf_rs1   = bus.id_rs1;
  assign bus.rf_rs2   = bus.id_rs2;
  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_op1   = ex_op1_q;
  assign bus.ex_op2   = ex_op2_q;
  assign bus.ex_rd    = ex_rd_q;

endmodule

// File: tb/tb_operand_scoreboard.sv
// Self-checking bench for operand_scoreboard: probe table, directed corner sequences, random run vs model.
module tb_operand_scoreboard;

  localparam int XLEN = 64;
  localparam int MAXP = 3;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  operand_scoreboard_if #(.XLEN(XLEN)) bus ();

  operand_scoreboard #(.CNT_W(2), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  logic [XLEN-1:0] rf_mem [32];
  assign bus.rf_q1 = rf_mem[bus.rf_rs1];
  assign bus.rf_q2 = rf_mem[bus.rf_rs2];

  int n_vec = 0;
  int n_err = 0;

  // reference model: outstanding writes per register, issue mode, execute buffer
  int              pend [32];
  int              mode;            // 0 run, 1 serialised, 2 recovering
  bit              m_exv;
  logic [XLEN-1:0] m_op1, m_op2;
  logic [4:0]      m_rd;
  bit              dut_rdy;
  int              cands [$];
  int              waited;
  logic [XLEN-1:0] e1, e2;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    bit         exr, flush, wbv;
    logic [4:0] wbrd;
    bit         exp;
  } probe_t;
  probe_t tbl [10];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    foreach (pend[i]) pend[i] = 0;
    mode  = 0;
    m_exv = 1'b0;
    m_op1 = '0;
    m_op2 = '0;
    m_rd  = '0;
  endtask

  function automatic bit src_ok(logic [4:0] s);
    if (s == 5'd0 || pend[s] == 0) return 1'b1;
    return BYP && pend[s] == 1 && bus.wb_valid && bus.wb_rd_we && bus.wb_rd == s;
  endfunction

  function automatic bit m_ready();
    return rst && mode == 0 && !bus.wb_flush && (!m_exv || bus.ex_ready)
           && src_ok(bus.id_rs1) && src_ok(bus.id_rs2) && pend[bus.id_rd] < MAXP;
  endfunction

  function automatic logic [XLEN-1:0] fwd(logic [4:0] s);
    if (BYP && s != 5'd0 && pend[s] == 1 && bus.wb_valid && bus.wb_rd_we && bus.wb_rd == s)
      return bus.wb_data;
    return rf_mem[s];
  endfunction

  task automatic m_update(input bit rdy);
    bit iss;
    bit wbw;
    iss = bus.id_valid && rdy;
    wbw = bus.wb_valid && bus.wb_rd_we && bus.wb_rd != 5'd0;
    if (!rst) begin
      m_reset();
      return;
    end
    if (bus.wb_flush) begin
      foreach (pend[i]) pend[i] = 0;
      m_exv = 1'b0;
      mode  = (mode == 2) ? 0 : 2;
    end else begin
      if (iss) begin
        m_op1 = fwd(bus.id_rs1);
        m_op2 = fwd(bus.id_rs2);
        m_rd  = bus.id_rd;
        m_exv = 1'b1;
        if (bus.id_rd_we && bus.id_rd != 5'd0) pend[bus.id_rd]++;
      end else if (bus.ex_ready) begin
        m_exv = 1'b0;
      end
      if (wbw) pend[bus.wb_rd]--;
      if (mode == 0 && iss && bus.id_is_csr) mode = 1;
      else if (mode == 1 && bus.wb_valid)    mode = 0;
      else if (mode == 2)                    mode = 0;
    end
    if (wbw) rf_mem[bus.wb_rd] = bus.wb_data;
  endtask

  task automatic idle();
    bus.id_valid  = 1'b0;
    bus.id_rs1    = '0;
    bus.id_rs2    = '0;
    bus.id_rd     = '0;
    bus.id_rd_we  = 1'b0;
    bus.id_is_csr = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_rd_we  = 1'b0;
    bus.wb_data   = '0;
    bus.wb_flush  = 1'b0;
    bus.ex_ready  = 1'b1;
  endtask

  // inputs are set at posedge+1; ready is checked mid-cycle, registered outputs at posedge+1
  task automatic step();
    bit r;
    #1;
    r       = m_ready();
    dut_rdy = bus.id_ready;
    chk("id_ready", {63'd0, bus.id_ready}, {63'd0, r});
    chk("rf_rs1", {59'd0, bus.rf_rs1}, {59'd0, bus.id_rs1});
    @(posedge clk);
    #1;
    m_update(r);
    chk("ex_valid", {63'd0, bus.ex_valid}, {63'd0, m_exv});
    if (m_exv) begin
      chk("ex_op1", bus.ex_op1, m_op1);
      chk("ex_op2", bus.ex_op2, m_op2);
      chk("ex_rd", {59'd0, bus.ex_rd}, {59'd0, m_rd});
    end
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit we, input bit csr);
    idle();
    bus.id_valid  = 1'b1;
    bus.id_rs1    = rs1;
    bus.id_rs2    = rs2;
    bus.id_rd     = rd;
    bus.id_rd_we  = we;
    bus.id_is_csr = csr;
  endtask

  task automatic retire(input logic [4:0] rd, input logic [XLEN-1:0] data);
    idle();
    bus.wb_valid = 1'b1;
    bus.wb_rd_we = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
  endtask

  initial begin
    tbl[0] = '{5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1};
    tbl[1] = '{5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0};
    tbl[2] = '{5'd0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0};
    tbl[3] = '{5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1};
    tbl[4] = '{5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0};
    tbl[5] = '{5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0};
    tbl[6] = '{5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, BYP};
    tbl[7] = '{5'd5, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, BYP};
    tbl[8] = '{5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0};
    tbl[9] = '{5'd3, 5'd4, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1};

    for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? '0 : {$urandom, $urandom};
    m_reset();

    // reset: decode offered but never accepted, buffer zeroed
    offer(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("rst_ready", {63'd0, bus.id_ready}, 64'd0);
      chk("rst_exv", {63'd0, bus.ex_valid}, 64'd0);
      chk("rst_op1", bus.ex_op1, 64'd0);
      chk("rst_op2", bus.ex_op2, 64'd0);
      chk("rst_rd", {59'd0, bus.ex_rd}, 64'd0);
    end
    rst = 1'b1;

    // x5 gets one pending write, then combinational ready probes
    offer(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      idle();
      bus.id_rs1   = tbl[k].rs1;
      bus.id_rs2   = tbl[k].rs2;
      bus.id_rd    = tbl[k].rd;
      bus.ex_ready = tbl[k].exr;
      bus.wb_flush = tbl[k].flush;
      bus.wb_valid = tbl[k].wbv;
      bus.wb_rd_we = tbl[k].wbv;
      bus.wb_rd    = tbl[k].wbrd;
      bus.wb_data  = 64'h1234;
      #1;
      chk($sformatf("probe%0d", k), {63'd0, bus.id_ready}, {63'd0, tbl[k].exp});
    end

    // RAW: x6 <= x5 waits for x5 to retire
    offer(5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    step();
    step();
    chk("raw_stall", {63'd0, dut_rdy}, 64'd0);
    waited = -1;
    for (int k = 0; k < 4; k++) begin
      bus.wb_valid = (k == 0);
      bus.wb_rd_we = (k == 0);
      bus.wb_rd    = 5'd5;
      bus.wb_data  = 64'h0000_0000_CAFE_ABCD;
      step();
      if (dut_rdy) begin
        waited = k;
        break;
      end
    end
    chk("raw_wait", 64'(waited), BYP ? 64'd0 : 64'd1);
    chk("raw_op1", bus.ex_op1, 64'h0000_0000_CAFE_ABCD);
    retire(5'd6, 64'h66);
    step();

    // x7 saturation: three writers in flight, the fourth waits for a retire
    for (int k = 0; k < 3; k++) begin
      offer(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
      step();
      chk("sat_issue", {63'd0, dut_rdy}, 64'd1);
    end
    offer(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    step();
    chk("sat_block", {63'd0, dut_rdy}, 64'd0);
    waited = -1;
    for (int k = 0; k < 4; k++) begin
      bus.wb_valid = (k == 0);
      bus.wb_rd_we = (k == 0);
      bus.wb_rd    = 5'd7;
      bus.wb_data  = 64'h77;
      step();
      if (dut_rdy) begin
        waited = k;
        break;
      end
    end
    chk("sat_wait", 64'(waited), 64'd1);
    for (int k = 0; k < 3; k++) begin
      retire(5'd7, 64'h700 + 64'(k));
      step();
    end

    // x0 as source and destination never stalls and reads zero
    for (int k = 0; k < 4; k++) begin
      offer(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      step();
      chk("x0_ready", {63'd0, dut_rdy}, 64'd1);
      chk("x0_op1", bus.ex_op1, 64'd0);
    end

    // CSR serialisation, then redirect and one recovery cycle
    offer(5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      offer(5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
      step();
      chk("csr_hold", {63'd0, dut_rdy}, 64'd0);
    end
    bus.wb_flush = 1'b1;
    step();
    chk("csr_flush_exv", {63'd0, bus.ex_valid}, 64'd0);
    offer(5'd9, 5'd0, 5'd4, 1'b0, 1'b0);
    step();
    chk("csr_recover", {63'd0, dut_rdy}, 64'd0);
    step();
    chk("csr_cleared", {63'd0, dut_rdy}, 64'd1);

    // execute back-pressure keeps the buffer stable
    offer(5'd10, 5'd11, 5'd12, 1'b0, 1'b0);
    step();
    e1 = rf_mem[10];
    e2 = rf_mem[11];
    for (int k = 0; k < 5; k++) begin
      offer(5'd1, 5'd0, 5'd2, 1'b0, 1'b0);
      bus.ex_ready = 1'b0;
      step();
      chk("bp_ready", {63'd0, dut_rdy}, 64'd0);
      chk("bp_op1", bus.ex_op1, e1);
      chk("bp_op2", bus.ex_op2, e2);
      chk("bp_rd", {59'd0, bus.ex_rd}, 64'd12);
    end
    idle();
    step();

    // async reset while serialised with two writes to x3 pending
    for (int k = 0; k < 2; k++) begin
      offer(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
      step();
    end
    offer(5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step();
    idle();
    bus.ex_ready = 1'b0;
    step();
    offer(5'd3, 5'd0, 5'd1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_exv", {63'd0, bus.ex_valid}, 64'd0);
    chk("arst_ready", {63'd0, bus.id_ready}, 64'd0);
    step();
    rst = 1'b1;
    step();
    chk("arst_run", {63'd0, dut_rdy}, 64'd1);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      bus.id_valid  = ($urandom_range(0, 9) < 7);
      bus.id_rs1    = 5'($urandom_range(0, 7));
      bus.id_rs2    = 5'($urandom_range(0, 7));
      bus.id_rd     = 5'($urandom_range(0, 7));
      bus.id_rd_we  = ($urandom_range(0, 3) != 0);
      bus.id_is_csr = ($urandom_range(0, 19) == 0);
      bus.ex_ready  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 49) == 0) begin
        bus.wb_flush = 1'b1;
      end else if ($urandom_range(0, 9) < 4) begin
        cands.delete();
        for (int i = 1; i < 32; i++) if (pend[i] > 0) cands.push_back(i);
        bus.wb_valid = 1'b1;
        bus.wb_data  = {$urandom, $urandom};
        if (cands.size() > 0 && $urandom_range(0, 4) != 0) begin
          bus.wb_rd_we = 1'b1;
          bus.wb_rd    = 5'(cands[$urandom_range(0, cands.size() - 1)]);
        end else begin
          bus.wb_rd_we = 1'b0;
          bus.wb_rd    = 5'($urandom_range(0, 31));
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
